// File: rtl/prf_wr_arbiter.sv
// PRF write arbiter: buffers register-file writes from each requester in a
// small FIFO and grants at most one write per PRF bank per cycle. Each bank
// has its own round-robin pointer.
module prf_wr_arbiter #(
  parameter int unsigned PRF_WR_COUNT             = 8,
  parameter int unsigned PRF_BANK_COUNT           = 4,
  parameter int unsigned PRF_WR_INPUT_BUFFER_SIZE = 2,
  parameter int unsigned LOG_PR_COUNT             = 7,
  parameter int unsigned XLEN                     = 32
) (
  input  logic                                         CLK,
  input  logic                                         nRST,
  input  logic [PRF_WR_COUNT-1:0]                      wr_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]    wr_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]            wr_data_by_wr,
  output logic [PRF_WR_COUNT-1:0]                      wr_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                    bank_wr_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-3:0]  bank_wr_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]          bank_wr_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][2:0]               bank_wr_src_by_bank
);

  localparam int unsigned SRC_W  = 3;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned UPR_W  = LOG_PR_COUNT - 2;
  localparam int unsigned DEPTH  = PRF_WR_INPUT_BUFFER_SIZE;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [LOG_PR_COUNT-1:0] pr;
    logic [XLEN-1:0]         data;
  } entry_t;

  entry_t           mem        [PRF_WR_COUNT][DEPTH];
  entry_t           head_entry [PRF_WR_COUNT];
  logic [CNT_W-1:0] count      [PRF_WR_COUNT];
  logic [PTR_W-1:0] head_ptr   [PRF_WR_COUNT];
  logic [PTR_W-1:0] tail_ptr   [PRF_WR_COUNT];

  logic [PRF_WR_COUNT-1:0]   enq;
  logic [PRF_WR_COUNT-1:0]   deq;
  logic [PRF_BANK_COUNT-1:0] gnt;
  logic [SRC_W-1:0]          win [PRF_BANK_COUNT];
  logic [SRC_W-1:0]          rr  [PRF_BANK_COUNT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on registered occupancy; head view per requester.
  always_comb begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      wr_ready_by_wr[i] = (count[i] < CNT_W'(DEPTH));
      enq[i]            = wr_valid_by_wr[i] && wr_ready_by_wr[i];
      head_entry[i]     = mem[i][head_ptr[i]];
    end
  end

  // Per-bank round-robin pick among non-empty FIFOs whose head targets the bank.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      gnt[b] = 1'b0;
      win[b] = '0;
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        idx = (int'(rr[b]) + k) % PRF_WR_COUNT;
        if (!gnt[b] && (count[idx] != '0) &&
            (head_entry[idx].pr[BANK_W-1:0] == BANK_W'(b))) begin
          gnt[b] = 1'b1;
          win[b] = SRC_W'(idx);
        end
      end
    end
  end

  // A requester's head targets one bank, so grants never collide on a FIFO.
  always_comb begin
    deq = '0;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (gnt[b] && (win[b] == SRC_W'(i))) begin
          deq[i] = 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (enq[i]) begin
        mem[i][tail_ptr[i]] <= '{pr: wr_PR_by_wr[i], data: wr_data_by_wr[i]};
      end
    end
  end

  // FIFO occupancy and pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        count[i]    <= '0;
        head_ptr[i] <= '0;
        tail_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
        if (enq[i]) tail_ptr[i] <= ptr_inc(tail_ptr[i]);
        if (deq[i]) head_ptr[i] <= ptr_inc(head_ptr[i]);
      end
    end
  end

  // Round-robin pointers move past the winner only when their bank grants.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) rr[b] <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (gnt[b]) begin
          rr[b] <= (win[b] == SRC_W'(PRF_WR_COUNT - 1)) ? '0 : win[b] + SRC_W'(1);
        end
      end
    end
  end

  // Registered bank write port; payload holds when the bank is idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_wr_valid_by_bank    <= '0;
      bank_wr_upper_PR_by_bank <= '0;
      bank_wr_data_by_bank     <= '0;
      bank_wr_src_by_bank      <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        bank_wr_valid_by_bank[b] <= gnt[b];
        if (gnt[b]) begin
          bank_wr_upper_PR_by_bank[b] <= head_entry[win[b]].pr[LOG_PR_COUNT-1:2];
          bank_wr_data_by_bank[b]     <= head_entry[win[b]].data;
          bank_wr_src_by_bank[b]      <= win[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// Directed bench for prf_wr_arbiter with hand-computed expectations.
module tb_prf_wr_arbiter;

  logic                 clk;
  logic                 nrst;
  logic [7:0]           wr_valid;
  logic [7:0][6:0]      wr_pr;
  logic [7:0][31:0]     wr_data;
  logic [7:0]           wr_ready;
  logic [3:0]           bank_valid;
  logic [3:0][4:0]      bank_upr;
  logic [3:0][31:0]     bank_data;
  logic [3:0][2:0]      bank_src;

  int checks = 0;
  int errors = 0;

  prf_wr_arbiter dut (
    .CLK                      (clk),
    .nRST                     (nrst),
    .wr_valid_by_wr           (wr_valid),
    .wr_PR_by_wr              (wr_pr),
    .wr_data_by_wr            (wr_data),
    .wr_ready_by_wr           (wr_ready),
    .bank_wr_valid_by_bank    (bank_valid),
    .bank_wr_upper_PR_by_bank (bank_upr),
    .bank_wr_data_by_bank     (bank_data),
    .bank_wr_src_by_bank      (bank_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    wr_valid = '0;
    #3;
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    nrst = 1'b0; wr_valid = '0; wr_pr = '0; wr_data = '0;
    #12 nrst = 1'b1;
    tick();
    check("rst_valid", 64'(bank_valid), 64'h0);
    check("rst_ready", 64'(wr_ready), 64'hFF);
    check("rst_src",   64'(bank_src), 64'h0);
    check("rst_upr",   64'(bank_upr), 64'h0);
    check("rst_data0", 64'(bank_data[0]), 64'h0);

    // Single write, req 3, bank 1.
    wr_valid[3] = 1'b1; wr_pr[3] = 7'h2D; wr_data[3] = 32'hDEADBEEF;
    tick();
    wr_valid = '0;
    check("t1_lat_valid", 64'(bank_valid), 64'h0);
    tick();
    check("t1_valid", 64'(bank_valid), 64'h2);
    check("t1_upr",   64'(bank_upr[1]), 64'h0B);
    check("t1_data",  64'(bank_data[1]), 64'hDEADBEEF);
    check("t1_src",   64'(bank_src[1]), 64'h3);
    tick();
    check("t1_idle",  64'(bank_valid), 64'h0);
    check("t1_hold",  64'(bank_upr[1]), 64'h0B);

    // All requesters hammer bank 0: strict rotation.
    for (int i = 0; i < 8; i++) begin
      wr_valid[i] = 1'b1; wr_pr[i] = 7'(i << 2); wr_data[i] = 32'(i);
    end
    tick();
    for (int k = 0; k < 11; k++) begin
      tick();
      check("t2_valid", 64'(bank_valid), 64'h1);
      check("t2_src",   64'(bank_src[0]), 64'(k % 8));
      check("t2_upr",   64'(bank_upr[0]), 64'(k % 8));
      check("t2_data",  64'(bank_data[0]), 64'(k % 8));
    end

    // Async reset with full FIFOs.
    #2 nrst = 1'b0;
    wr_valid = '0;
    #1;
    check("rst2_valid", 64'(bank_valid), 64'h0);
    check("rst2_ready", 64'(wr_ready), 64'hFF);
    check("rst2_src",   64'(bank_src), 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    check("rst2_nostale", 64'(bank_valid), 64'h0);
    tick();
    check("rst2_nostale2", 64'(bank_valid), 64'h0);

    // Four banks at once; req 7 also on bank 0 shows rr[0] was cleared.
    for (int i = 0; i < 4; i++) begin
      wr_valid[i] = 1'b1; wr_pr[i] = 7'(4 + i); wr_data[i] = 32'(32'h100 + i);
    end
    wr_valid[7] = 1'b1; wr_pr[7] = 7'h08; wr_data[7] = 32'h107;
    tick();
    wr_valid = '0;
    check("t3_lat", 64'(bank_valid), 64'h0);
    tick();
    check("t3_valid", 64'(bank_valid), 64'hF);
    for (int b = 0; b < 4; b++) begin
      check("t3_src",  64'(bank_src[b]), 64'(b));
      check("t3_upr",  64'(bank_upr[b]), 64'h1);
      check("t3_data", 64'(bank_data[b]), 64'(32'h100 + b));
    end
    tick();
    check("t3b_valid", 64'(bank_valid), 64'h1);
    check("t3b_src",   64'(bank_src[0]), 64'h7);
    check("t3b_upr",   64'(bank_upr[0]), 64'h2);
    check("t3b_data",  64'(bank_data[0]), 64'h107);
    check("t3_ready",  64'(wr_ready), 64'hFF);

    // Req 5 back-pressured behind reqs 0..4 on bank 2.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_valid[i] = 1'b1; wr_pr[i] = 7'((i << 2) | 2); wr_data[i] = 32'(32'h100 + i);
    end
    wr_valid[5] = 1'b1; wr_pr[5] = 7'h16; wr_data[5] = 32'h5000000A;
    tick();
    wr_valid[4:0] = '0;
    wr_pr[5] = 7'h1A; wr_data[5] = 32'h5000000B;
    tick();
    check("t4_src0",   64'(bank_src[2]), 64'h0);
    check("t4_valid0", 64'(bank_valid), 64'h4);
    check("t4_full",   64'(wr_ready[5]), 64'h0);
    wr_pr[5] = 7'h1E; wr_data[5] = 32'h5000000C;
    for (int k = 1; k < 5; k++) begin
      tick();
      check("t4_src",   64'(bank_src[2]), 64'(k));
      check("t4_valid", 64'(bank_valid), 64'h4);
      check("t4_held",  64'(wr_ready[5]), 64'h0);
    end
    tick();
    check("t4_a_src",  64'(bank_src[2]), 64'h5);
    check("t4_a_data", 64'(bank_data[2]), 64'h5000000A);
    check("t4_a_upr",  64'(bank_upr[2]), 64'h5);
    check("t4_ready",  64'(wr_ready[5]), 64'h1);
    tick();
    wr_valid[5] = 1'b0;
    check("t4_b_data", 64'(bank_data[2]), 64'h5000000B);
    check("t4_b_upr",  64'(bank_upr[2]), 64'h6);
    tick();
    check("t4_c_valid", 64'(bank_valid), 64'h4);
    check("t4_c_data",  64'(bank_data[2]), 64'h5000000C);
    check("t4_c_upr",   64'(bank_upr[2]), 64'h7);
    tick();
    check("t4_drain", 64'(bank_valid), 64'h0);

    // Uncontended streaming at one write per cycle from req 6.
    wr_valid[6] = 1'b1; wr_pr[6] = 7'h03; wr_data[6] = 32'h600;
    tick();
    for (int k = 1; k <= 4; k++) begin
      check("t5_ready", 64'(wr_ready[6]), 64'h1);
      if (k < 4) begin
        wr_pr[6] = 7'((k << 2) | 3); wr_data[6] = 32'(32'h600 + k);
      end else begin
        wr_valid[6] = 1'b0;
      end
      tick();
      check("t5_valid", 64'(bank_valid), 64'h8);
      check("t5_data",  64'(bank_data[3]), 64'(32'h600 + k - 1));
      check("t5_src",   64'(bank_src[3]), 64'h6);
    end
    tick();
    check("t5_idle", 64'(bank_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
